// File: rtl/arkhe_seed_arbiter.sv
// Two-entry seed buffer gated on acoustic coherence, delivered round-robin to NREQ consumers.
// A grant appears one cycle after level>=1 meets an eligible req; when the buffer is full, the incoming seed is dropped and counted.
module arkhe_seed_arbiter #(
    parameter int          NREQ         = 4,
    parameter logic [15:0] PHI_MIN      = 16'hD999,
    parameter logic [15:0] SEED_TIMEOUT = 16'd50000,
    parameter logic [15:0] STARVE_LIMIT = 16'd1024
) (
    input  logic            clk_100mhz,
    input  logic            rst,
    input  logic [255:0]    seed_in,
    input  logic            seed_in_valid,
    input  logic [63:0]     phi_in,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [255:0]    seed_out,
    output logic            seed_out_valid,
    output logic [1:0]      buffer_level,
    output logic            starve_alarm,
    output logic [15:0]     drop_count,
    output logic [15:0]     evict_count
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, SERVE, STARVED} state_t;

    state_t          state, state_n;
    logic [255:0]    head, tail, head_n, tail_n;
    logic [15:0]     age, age_n, starve_cnt, starve_n;
    logic [IW-1:0]   last_grant, pick_idx, idx;
    logic [NREQ-1:0] elig;
    logic [1:0]      lvl_rem, lvl_n;
    logic            push, found, do_grant, evict, remove, accept, drop;
    logic            unused_phi;

    assign unused_phi = ^{phi_in[63:48], phi_in[31:0]};

    always_comb begin
        push     = seed_in_valid && (phi_in[47:32] > PHI_MIN);
        elig     = req & ~grant;
        found    = 1'b0;
        pick_idx = '0;
        idx      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = IW'((int'(last_grant) + i) % NREQ);
            if (!found && elig[idx]) begin
                found    = 1'b1;
                pick_idx = idx;
            end
        end
        do_grant = found && (buffer_level != 2'd0);
        // A grant always beats eviction of the same head.
        evict    = !do_grant && (buffer_level != 2'd0) && (age >= SEED_TIMEOUT);
        remove   = do_grant || evict;
        lvl_rem  = buffer_level - {1'b0, remove};
        accept   = push && (lvl_rem != 2'd2);
        drop     = push && !accept;
        lvl_n    = lvl_rem + {1'b0, accept};

        head_n = remove ? tail : head;
        tail_n = tail;
        if (accept) begin
            if (lvl_rem == 2'd0) head_n = seed_in;
            else                 tail_n = seed_in;
        end

        if (lvl_n == 2'd0 || remove || (accept && lvl_rem == 2'd0)) age_n = '0;
        else if (age != 16'hFFFF)                                   age_n = age + 16'd1;
        else                                                        age_n = age;

        if (req != '0 && buffer_level == 2'd0)
            starve_n = (starve_cnt != 16'hFFFF) ? starve_cnt + 16'd1 : starve_cnt;
        else
            starve_n = '0;

        state_n = state;
        case (state)
            IDLE:    if (lvl_n != 2'd0)                 state_n = SERVE;
                     else if (starve_n >= STARVE_LIMIT) state_n = STARVED;
            SERVE:   if (lvl_n == 2'd0)                 state_n = IDLE;
            STARVED: if (accept)                        state_n = SERVE;
            default:                                    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            state          <= IDLE;
            head           <= '0;
            tail           <= '0;
            buffer_level   <= '0;
            age            <= '0;
            starve_cnt     <= '0;
            last_grant     <= IW'(NREQ - 1);
            grant          <= '0;
            seed_out       <= '0;
            seed_out_valid <= 1'b0;
            starve_alarm   <= 1'b0;
            drop_count     <= '0;
            evict_count    <= '0;
        end else begin
            state          <= state_n;
            head           <= head_n;
            tail           <= tail_n;
            buffer_level   <= lvl_n;
            age            <= age_n;
            starve_cnt     <= starve_n;
            grant          <= do_grant ? (NREQ'(1) << pick_idx) : '0;
            seed_out_valid <= do_grant;
            starve_alarm   <= (state_n == STARVED);
            if (do_grant) begin
                seed_out   <= head;
                last_grant <= pick_idx;
            end
            if (drop && drop_count != 16'hFFFF)   drop_count  <= drop_count + 16'd1;
            if (evict && evict_count != 16'hFFFF) evict_count <= evict_count + 16'd1;
        end
    end

endmodule

// File: doc/arkhe_seed_arbiter.md
ARKHE_SEED_ARBITER -- requirements
Module: arkhe_seed_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  NREQ  4  number of seed consumers, 2..8.
  PHI_MIN  16'hD999  coherence gate; compared against phi_in[47:32].
  SEED_TIMEOUT  16'd50000  maximum head-of-buffer seed age, in cycles.
  STARVE_LIMIT  16'd1024  consecutive starved cycles before alarm.
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk_100mhz  in  1  single clock; all logic on its rising edge.
  rst  in  1  synchronous, active-high reset.
  seed_in  in  256  candidate seed from the acoustic coherence datapath.
  seed_in_valid  in  1  seed_in is valid this cycle.
  phi_in  in  64  acoustic coherence, Q16.48.
  req  in  NREQ  per-consumer seed request, level, held until granted.
  grant  out  NREQ  one-hot delivery strobe, one cycle long.
  seed_out  out  256  delivered seed; valid only while seed_out_valid=1.
  seed_out_valid  out  1  high exactly when grant != 0.
  buffer_level  out  2  seeds held: 0, 1 or 2.
  starve_alarm  out  1  high while in STARVED.
  drop_count  out  16  seeds lost to a full buffer; saturates at 16'hFFFF.
  evict_count  out  16  seeds discarded as stale; saturates at 16'hFFFF.

Function
REQ-003 Buffer: 2-entry FIFO of 256-bit seeds; head age counter is 16 bits.
REQ-004 Push condition: seed_in_valid=1 AND phi_in[47:32] > PHI_MIN (strictly greater); ungated seeds are silently ignored and not counted.
REQ-005 A qualified push while level=2 with no pop in the same cycle: seed dropped, drop_count+1; a push and pop in the same cycle at level=2 are both accepted.
REQ-006 Arbitration: round-robin. Search starts at index last_grant+1 mod NREQ; last_grant resets to NREQ-1 (index 0 has first priority).
REQ-007 Grant timing: grant, seed_out and seed_out_valid are registered.
  - A grant is issued in cycle N+1 when cycle N has level>=1 and an eligible req.
  - Eligible req: req & ~mask, where mask is the previous cycle's grant; this masks a requester for one cycle after it is granted.
  - The grant pops the head in the same edge, and seed_out equals the popped head.
REQ-008 At most one grant per cycle; no push-to-grant bypass. A seed pushed into an empty buffer in cycle N is grantable no earlier than cycle N+2.
REQ-009 Head age:
  - Resets to 0 whenever the head changes (pop, or push into an empty buffer).
  - Increments once per cycle otherwise.
  - When age reaches SEED_TIMEOUT and no grant is issued that cycle, the head is discarded and evict_count+1.
  - A grant takes priority over eviction in the same cycle.
REQ-010 FSM states are IDLE, SERVE and STARVED; the state register resets to IDLE.
  - IDLE -> SERVE when level becomes nonzero.
  - SERVE -> IDLE when level becomes 0.
  - IDLE -> STARVED when req != 0 and level = 0 for STARVE_LIMIT consecutive cycles.
  - STARVED -> SERVE on the first qualified push.
  - The starve counter clears whenever req = 0 or level != 0.
REQ-011 starve_alarm is a registered decode of STARVED.
REQ-012 Deasserting req before grant withdraws the request, with no error. A req that deasserts in the cycle its grant is registered is still served (seed consumed).
REQ-013 Counters saturate and never wrap. buffer_level always reflects the post-edge FIFO occupancy.

Reset
REQ-014 While rst=1 on a clock edge, all of the following are set on that edge:
  - state=IDLE; FIFO emptied; buffer_level=0.
  - grant=0, seed_out=0, seed_out_valid=0, starve_alarm=0.
  - drop_count=0, evict_count=0; head age and starve counter = 0; last_grant=NREQ-1.
REQ-015 Reset asserted mid-delivery: no grant is issued on the following cycle; buffered seeds are lost and not counted.

Verification
REQ-016 Empty DUT; push seed A with phi_in[47:32]=16'hE000; req=4'b0001 held. Required: grant=0001 with seed_out=A exactly 2 cycles after the push cycle; buffer_level returns to 0.
REQ-017 Two seeds buffered; req=4'b1111 held. Required: grants 0001 then 0010 on consecutive eligible cycles; then no grant while level=0; the next seed goes to 0100.
REQ-018 Push with phi_in[47:32]=16'hD999. Required: ignored, buffer_level stays 0, drop_count stays 0. Three qualified pushes with no req: buffer_level=2, drop_count=1.
REQ-019 One seed buffered, no req for 50000 cycles. Required: evicted, evict_count=1, buffer_level=0. With req rising on the timeout cycle, the grant wins and evict_count stays 0.
REQ-020 req=0001, no seeds for 1024 cycles. Required: starve_alarm=1. One qualified push: starve_alarm=0 next cycle, then grant=0001. Assert rst mid-sequence: all outputs return to reset values on the next edge.
